// File: rtl/ymux_pkg.sv
// Shared definitions for the ymux round-robin arbiter slice:
// output-slot state encoding and default channel geometry.
package ymux_pkg;

  // Output register occupancy: EMPTY has no word, FULL presents one downstream.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int SIZE_DEFAULT = 32;
  localparam int N_DEFAULT    = 4;

endpackage

// File: rtl/ymux_rr_pick.sv
// Circular priority picker: returns the first requesting index found when
// searching upward from 'start' with wrap from N-1 to 0. A start of zero
// gives plain lowest-index-wins priority.
module ymux_rr_pick #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] start,
  output logic [SW-1:0] grant,
  output logic          any
);

  int            idx;
  logic [SW-1:0] idx_s;

  // Scan from the farthest candidate back to 'start' so the nearest requester
  // in circular order is the last one written and therefore wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    idx_s = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      idx_s = SW'(idx);
      if (req[idx_s]) begin
        grant = idx_s;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ymux_rr_arb.sv
// N-to-1 arbitrating multiplexer with a one-entry registered output stage.
// mode=0 selects lowest-index priority, mode=1 round-robin from a pointer
// that always advances past the most recent grant.
module ymux_rr_arb
  import ymux_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT,
  parameter int N    = N_DEFAULT,
  parameter int SW   = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic [N-1:0]      in_valid,
  input  logic [N*SIZE-1:0] in_data,
  output logic [N-1:0]      in_ready,
  output logic              out_valid,
  output logic [SIZE-1:0]   out_data,
  output logic [SW-1:0]     out_sel,
  input  logic              out_ready
);

  state_t          state_reg, state_next;
  logic [SW-1:0]   ptr_reg, ptr_next;
  logic [SIZE-1:0] out_data_reg;
  logic [SW-1:0]   out_sel_reg;

  logic [SW-1:0]   pick_start;
  logic [SW-1:0]   grant_idx;
  logic            grant_any;
  logic            slot_free;
  logic            grant_fire;
  logic [SIZE-1:0] chan_data [N];

  // The pointer is kept in both modes so switching mode needs no flush.
  assign pick_start = mode ? ptr_reg : '0;

  ymux_rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .req   (in_valid),
    .start (pick_start),
    .grant (grant_idx),
    .any   (grant_any)
  );

  // Channel word view and one-hot accept strobes.
  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    assign chan_data[gi] = in_data[gi*SIZE +: SIZE];
    assign in_ready[gi]  = grant_fire && (grant_idx == SW'(gi));
  end

  // Next-state, grant qualification and pointer advance.
  always_comb begin
    slot_free  = (state_reg == EMPTY) || out_ready;
    grant_fire = slot_free && grant_any && !reset;
    state_next = state_reg;
    ptr_next   = ptr_reg;
    if (slot_free) begin
      state_next = grant_any ? FULL : EMPTY;
    end
    if (grant_fire) begin
      ptr_next = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
    end
  end

  // FSM state register; reset discards any held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Output word, source index and round-robin pointer; load only on a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_reg <= '0;
      out_sel_reg  <= '0;
      ptr_reg      <= '0;
    end else if (grant_fire) begin
      out_data_reg <= chan_data[grant_idx];
      out_sel_reg  <= grant_idx;
      ptr_reg      <= ptr_next;
    end
  end

  assign out_valid = (state_reg == FULL);
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_ymux_rr_arb.sv
// Scoreboard bench for ymux_rr_arb across three geometries (N=4/32b, N=2/8b,
// N=5/32b). Stimulus drives inputs at the falling edge and predicts in_ready
// from a circular-search reference; granted words are queued and a separate
// monitor pops and compares whenever the DUT hands a word downstream.
module tb_ymux_rr_arb;

  logic clk;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   done [3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string nm, input int cfg_n,
                                input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (N=%0d): got %0h, expected %0h", nm, cfg_n, act, exp);
    end
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int NC  = (gi == 1) ? 2 : ((gi == 2) ? 5 : 4);
    localparam int SC  = (gi == 1) ? 8 : 32;
    localparam int SWC = $clog2(NC);

    logic             reset;
    logic             mode;
    logic [NC-1:0]    in_valid;
    logic [NC*SC-1:0] in_data;
    logic [NC-1:0]    in_ready;
    logic             out_valid;
    logic [SC-1:0]    out_data;
    logic [SWC-1:0]   out_sel;
    logic             out_ready;

    ymux_rr_arb #(
      .SIZE (SC),
      .N    (NC)
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
    );

    // Reference state: words owed downstream, occupancy and search pointer.
    logic [SC-1:0] q_data [$];
    int            q_sel  [$];
    bit            m_full;
    bit            m_known;
    bit            m_after_rst;
    int            m_ptr;

    task automatic cycle(input bit rst, input bit md, input int unsigned vmask,
                         input bit ordy, input bit use_fix, input logic [31:0] fix);
      int            g;
      int            start;
      int            c;
      bit            free;
      logic [NC-1:0] exp_rdy;
      logic [31:0]   r;
      @(negedge clk);
      reset     = rst;
      mode      = md;
      out_ready = ordy;
      in_valid  = vmask[NC-1:0];
      for (int ch = 0; ch < NC; ch++) begin
        r = $urandom();
        if (use_fix && ch == 0) r = fix;
        in_data[ch*SC +: SC] = r[SC-1:0];
      end
      #1;
      if (m_known) check("out_valid", NC, 64'(out_valid), 64'(m_full));
      if (m_after_rst) begin
        check("reset_out_data", NC, 64'(out_data), 64'd0);
        check("reset_out_sel", NC, 64'(out_sel), 64'd0);
      end
      m_after_rst = rst;
      exp_rdy = '0;
      if (rst) begin
        check("in_ready_reset", NC, 64'(in_ready), 64'(exp_rdy));
        m_known = 1'b1;
        m_full  = 1'b0;
        m_ptr   = 0;
        q_data.delete();
        q_sel.delete();
      end else begin
        free = !m_full || ordy;
        g    = -1;
        if (free) begin
          start = md ? m_ptr : 0;
          for (int k = 0; k < NC; k++) begin
            c = (start + k) % NC;
            if (g < 0 && vmask[c]) g = c;
          end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("in_ready", NC, 64'(in_ready), 64'(exp_rdy));
        if (g >= 0) begin
          q_data.push_back(in_data[g*SC +: SC]);
          q_sel.push_back(g);
          m_ptr  = (g + 1) % NC;
          m_full = 1'b1;
        end else if (free) begin
          m_full = 1'b0;
        end
      end
    endtask

    // Monitor: pop on each downstream handshake, otherwise confirm the hold.
    initial begin
      logic [SC-1:0] exp_d;
      int            exp_s;
      forever begin
        @(negedge clk);
        #2;
        if (reset === 1'b0 && out_valid === 1'b1) begin
          if (q_data.size() == 0) begin
            check("pending_words", NC, 64'(q_data.size()), 64'd1);
          end else if (out_ready === 1'b1) begin
            exp_d = q_data.pop_front();
            exp_s = q_sel.pop_front();
            check("out_data", NC, 64'(out_data), 64'(exp_d));
            check("out_sel", NC, 64'(out_sel), 64'(exp_s));
          end else begin
            check("hold_data", NC, 64'(out_data), 64'(q_data[0]));
            check("hold_sel", NC, 64'(out_sel), 64'(q_sel[0]));
          end
        end
      end
    end

    // Directed corner sequences, then constrained-random traffic.
    initial begin
      bit          md_r;
      bit          rdy_r;
      int unsigned v_r;
      cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, 32'h0);
      // Fixed priority picks the lowest requester.
      cycle(1'b0, 1'b0, 'b1010, 1'b1, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h0);
      // Round-robin from a fresh pointer with all channels requesting.
      cycle(1'b1, 1'b1, 0, 1'b0, 1'b0, 32'h0);
      repeat (8) cycle(1'b0, 1'b1, 'hF, 1'b1, 1'b0, 32'h0);
      // Backpressure while holding channel 2, then release.
      cycle(1'b0, 1'b1, 'b0100, 1'b1, 1'b0, 32'h0);
      repeat (3) cycle(1'b0, 1'b1, 'hF, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 'hF, 1'b1, 1'b0, 32'h0);
      // Pointer wrap: grant 2 moves ptr to 3, then 0110 must pick 1.
      cycle(1'b0, 1'b1, 'b0100, 1'b1, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 'b0110, 1'b1, 1'b0, 32'h0);
      // Reset discards a held word; next grant starts from pointer 0.
      cycle(1'b0, 1'b1, 'b0001, 1'b1, 1'b1, 32'hDEADBEEF);
      cycle(1'b0, 1'b1, 0, 1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 'hF, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 'hF, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 200; i++) begin
        md_r  = 1'($urandom_range(0, 1));
        rdy_r = ($urandom_range(0, 9) < 7);
        v_r   = $urandom();
        cycle(1'b0, md_r, v_r, rdy_r, 1'b0, 32'h0);
      end
      repeat (3) cycle(1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h0);
      check("leftover_words", NC, 64'(q_data.size()), 64'd0);
      done[gi] = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(done[0] && done[1] && done[2]) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (!(done[0] && done[1] && done[2])) begin
      miscompares++;
      $display("FAIL timeout: got %0d cycles, expected completion within 20000", t);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
